// File: rtl/integer_register_read_stage_pkg.sv
// Shared op bundle, widths and flush-range helper for the integer RR stage.
// Optional perf counters are built when RSD_INT_RR_PERF_COUNTER_EN is defined.
package integer_register_read_stage_pkg;

    localparam int RR_AL_PTR_W = 6;
    localparam int RR_PREG_W   = 7;
    localparam int RR_DATA_W   = 32;
    localparam int RR_OPID_W   = 8;
    localparam int RR_OPC_W    = 6;
    localparam int RR_IMM_W    = 16;

    typedef logic [RR_AL_PTR_W-1:0] al_ptr_t;
    typedef logic [RR_PREG_W-1:0]   preg_t;

    typedef struct packed {
        logic [RR_OPID_W-1:0] opId;
        al_ptr_t              alPtr;
        preg_t                srcA;
        preg_t                srcB;
        preg_t                dst;
        logic [RR_OPC_W-1:0]  opcode;
        logic [RR_IMM_W-1:0]  imm;
    } IntRROp;

    // Circular [head, tail); head == tail is empty unless flushAll.
    function automatic logic in_flush_range(
        input logic    rec,
        input logic    all,
        input al_ptr_t p,
        input al_ptr_t head,
        input al_ptr_t tail
    );
        logic hit;
        if (head <= tail) hit = (p >= head) && (p < tail);
        else              hit = (p >= head) || (p < tail);
        return rec && (all || hit);
    endfunction

endpackage

// File: rtl/int_rr_operand_bypass.sv
// Per-source operand mux: lowest-index matching writeback port wins,
// otherwise the register-file read data is used.
module int_rr_operand_bypass #(
    parameter int PREG_W   = 7,
    parameter int DATA_W   = 32,
    parameter int WB_PORTS = 2
) (
    input  logic [PREG_W-1:0]   src,
    input  logic [DATA_W-1:0]   rf_data,
    input  logic [WB_PORTS-1:0] wb_valid,
    input  logic [PREG_W-1:0]   wb_dst  [WB_PORTS],
    input  logic [DATA_W-1:0]   wb_data [WB_PORTS],
    output logic [DATA_W-1:0]   opnd
);

    // Scan from the highest port down so the lowest match is applied last.
    always_comb begin
        opnd = rf_data;
        for (int w = WB_PORTS - 1; w >= 0; w--) begin
            if (wb_valid[w] && (wb_dst[w] == src)) opnd = wb_data[w];
        end
    end

endmodule

// File: rtl/integer_register_read_stage.sv
// Integer register-read stage: op latch, RF address drive, bypass, flush.
// Define RSD_INT_RR_PERF_COUNTER_EN for perfFlushCount / perfStallCount.
module integer_register_read_stage
    import integer_register_read_stage_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int AL_PTR_W = RR_AL_PTR_W,
    parameter int PREG_W   = RR_PREG_W,
    parameter int DATA_W   = RR_DATA_W,
    parameter int WB_PORTS = 2
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                stall,
    input  logic                clear,
    input  logic [LANES-1:0]    inValid,
    input  IntRROp              inOp     [LANES],
    input  logic                toRecoveryPhase,
    input  logic                flushAll,
    input  logic [AL_PTR_W-1:0] flushHead,
    input  logic [AL_PTR_W-1:0] flushTail,
    output logic [PREG_W-1:0]   rfAddr   [2*LANES],
    input  logic [DATA_W-1:0]   rfData   [2*LANES],
    input  logic [WB_PORTS-1:0] wbValid,
    input  logic [PREG_W-1:0]   wbDst    [WB_PORTS],
    input  logic [DATA_W-1:0]   wbData   [WB_PORTS],
    output logic [LANES-1:0]    outValid,
    output IntRROp              outOp    [LANES],
    output logic [DATA_W-1:0]   outA     [LANES],
    output logic [DATA_W-1:0]   outB     [LANES]
`ifdef RSD_INT_RR_PERF_COUNTER_EN
    ,
    output logic [31:0]         perfFlushCount,
    output logic [31:0]         perfStallCount
`endif
);

    logic [LANES-1:0]  valid_q;
    IntRROp            op_q   [LANES];
    logic [LANES-1:0]  fl_in;
    logic [LANES-1:0]  fl_held;
    logic [DATA_W-1:0] opnd   [2*LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign fl_in[i] = in_flush_range(toRecoveryPhase, flushAll,
                                         inOp[i].alPtr,
                                         flushHead, flushTail);
        assign fl_held[i] = in_flush_range(toRecoveryPhase, flushAll,
                                           op_q[i].alPtr,
                                           flushHead, flushTail);
        assign outValid[i] = valid_q[i] && !clear && !fl_held[i];
        assign outOp[i]    = op_q[i];
        assign outA[i]     = opnd[2*i];
        assign outB[i]     = opnd[2*i+1];
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_q <= '0;
            for (int i = 0; i < LANES; i++) op_q[i] <= '0;
        end else if (!stall) begin
            valid_q <= inValid & ~fl_in & {LANES{!clear}};
            for (int i = 0; i < LANES; i++) op_q[i] <= inOp[i];
        end else begin
            valid_q <= outValid;
        end
    end

    // Even index reads srcA, odd index srcB; invalid lanes still drive.
    for (genvar g = 0; g < 2*LANES; g++) begin : g_src
        if (g % 2 == 0) begin : g_a
            assign rfAddr[g] = op_q[g/2].srcA;
        end else begin : g_b
            assign rfAddr[g] = op_q[g/2].srcB;
        end

        int_rr_operand_bypass #(
            .PREG_W   (PREG_W),
            .DATA_W   (DATA_W),
            .WB_PORTS (WB_PORTS)
        ) u_byp (
            .src      (rfAddr[g]),
            .rf_data  (rfData[g]),
            .wb_valid (wbValid),
            .wb_dst   (wbDst),
            .wb_data  (wbData),
            .opnd     (opnd[g])
        );
    end

`ifdef RSD_INT_RR_PERF_COUNTER_EN
    logic [LANES-1:0] kill;
    logic [31:0]      kill_cnt;
    logic [32:0]      flush_sum;

    assign kill = valid_q & ~outValid;

    always_comb begin
        kill_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            kill_cnt = kill_cnt + 32'(kill[i]);
        end
    end

    assign flush_sum = {1'b0, perfFlushCount} + {1'b0, kill_cnt};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            perfFlushCount <= '0;
            perfStallCount <= '0;
        end else begin
            perfFlushCount <= flush_sum[32] ? '1 : flush_sum[31:0];
            if (stall && |valid_q && perfStallCount != '1) begin
                perfStallCount <= perfStallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_integer_register_read_stage.sv
// Scoreboard bench for integer_register_read_stage.
// Perf counter checks build only with RSD_INT_RR_PERF_COUNTER_EN.
module tb_integer_register_read_stage;
    import integer_register_read_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stall;
    logic        clear;
    logic [1:0]  inValid;
    IntRROp      inOp [2];
    logic        toRec;
    logic        flushAll;
    logic [5:0]  flushHead;
    logic [5:0]  flushTail;
    logic [6:0]  rfAddr [4];
    logic [31:0] rfData [4];
    logic [1:0]  wbValid;
    logic [6:0]  wbDst [2];
    logic [31:0] wbData [2];
    logic [1:0]  outValid;
    IntRROp      outOp [2];
    logic [31:0] outA [2];
    logic [31:0] outB [2];
`ifdef RSD_INT_RR_PERF_COUNTER_EN
    logic [31:0] pf;
    logic [31:0] ps;
`endif

    logic [31:0] rf_mem [128];

    typedef struct packed {
        logic [1:0] v;
        IntRROp     op1;
        IntRROp     op0;
    } exp_t;

    exp_t sbq [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_rf
        assign rfData[k] = rf_mem[rfAddr[k]];
    end

    integer_register_read_stage dut (
        .clk             (clk),
        .rstN            (rstN),
        .stall           (stall),
        .clear           (clear),
        .inValid         (inValid),
        .inOp            (inOp),
        .toRecoveryPhase (toRec),
        .flushAll        (flushAll),
        .flushHead       (flushHead),
        .flushTail       (flushTail),
        .rfAddr          (rfAddr),
        .rfData          (rfData),
        .wbValid         (wbValid),
        .wbDst           (wbDst),
        .wbData          (wbData),
        .outValid        (outValid),
        .outOp           (outOp),
        .outA            (outA),
        .outB            (outB)
`ifdef RSD_INT_RR_PERF_COUNTER_EN
        ,
        .perfFlushCount  (pf),
        .perfStallCount  (ps)
`endif
    );

    function automatic IntRROp rand_op();
        IntRROp o;
        o.opId   = 8'($urandom);
        o.alPtr  = 6'($urandom_range(10, 50));
        o.srcA   = 7'($urandom_range(0, 15));
        o.srcB   = 7'($urandom_range(0, 15));
        o.dst    = 7'($urandom);
        o.opcode = 6'($urandom);
        o.imm    = 16'($urandom);
        return o;
    endfunction

    function automatic logic [31:0] exp_opnd(input logic [6:0] s);
        logic [31:0] r;
        r = rf_mem[s];
        for (int w = 1; w >= 0; w--) begin
            if (wbValid[w] && wbDst[w] == s) r = wbData[w];
        end
        return r;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (outValid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outvalid got %b want 00", outValid);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rfAddr[k] !== 7'd0) begin
                n_fail++;
                $display("FAIL reset_rfaddr%0d got %0d want 0", k, rfAddr[k]);
            end
        end
        n_checks++;
        if (outOp[0] !== IntRROp'(0)) begin
            n_fail++;
            $display("FAIL reset_payload got %h want 0", outOp[0]);
        end
`ifdef RSD_INT_RR_PERF_COUNTER_EN
        n_checks++;
        if (pf !== 32'd0 || ps !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf got %0d/%0d want 0/0", pf, ps);
        end
`endif
        rstN = 1'b1;
    endtask

`ifdef RSD_INT_RR_PERF_COUNTER_EN
    task automatic test_perf();
        @(negedge clk);
        inValid = 2'b11;
        inOp[0] = rand_op();
        inOp[1] = rand_op();
        @(posedge clk); #1;
        inValid = 2'b00;
        clear   = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n_checks++;
        if (pf !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_flush got %0d want 2", pf);
        end
        inValid = 2'b11;
        @(posedge clk); #1;
        inValid = 2'b00;
        stall   = 1'b1;
        @(posedge clk); #1;
        stall = 1'b0;
        n_checks++;
        if (ps !== 32'd1 || pf !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_stall got %0d/%0d want 1/2", ps, pf);
        end
    endtask
`endif

    task automatic test_basic();
        exp_t e;
        @(negedge clk);
        stall   = 1'b0;
        clear   = 1'b0;
        toRec   = 1'b0;
        wbValid = 2'b00;
        inValid = 2'b11;
        inOp[0] = rand_op();
        inOp[0].srcA = 7'd5;
        inOp[1] = rand_op();
        sbq.push_back('{v: 2'b11, op1: inOp[1], op0: inOp[0]});
        @(posedge clk); #1;
        inValid = 2'b00;
        #1;
        n_checks++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL basic_sb got empty want entry");
        end else begin
            e = sbq.pop_front();
            if (outValid !== e.v || outOp[0] !== e.op0 ||
                outOp[1] !== e.op1 || outA[0] !== 32'h11 ||
                outB[0] !== exp_opnd(e.op0.srcB) ||
                outA[1] !== exp_opnd(e.op1.srcA)) begin
                n_fail++;
                $display("FAIL basic v=%b a0=%h want v=%b a0=11",
                         outValid, outA[0], e.v);
            end
        end
        n_checks++;
        if (rfAddr[0] !== 7'd5) begin
            n_fail++;
            $display("FAIL basic_rfaddr got %0d want 5", rfAddr[0]);
        end
    endtask

    task automatic test_stall_bypass();
        logic [1:0]  wv [4];
        IntRROp      held;
        logic [31:0] want;
        wv[0] = 2'b11;
        wv[1] = 2'b10;
        wv[2] = 2'b01;
        wv[3] = 2'b00;
        @(negedge clk);
        inValid = 2'b11;
        inOp[0] = rand_op();
        inOp[1] = rand_op();
        inOp[1].srcB = 7'd9;
        held = inOp[1];
        @(posedge clk); #1;
        stall   = 1'b1;
        inValid = 2'b00;
        inOp[1] = rand_op();
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            wbValid   = wv[j];
            wbDst[0]  = 7'd9;
            wbDst[1]  = 7'd9;
            wbData[0] = 32'hAA;
            wbData[1] = 32'hBB;
            #1;
            want = wv[j][0] ? 32'hAA : (wv[j][1] ? 32'hBB : rf_mem[9]);
            n_checks++;
            if (outB[1] !== want || outOp[1] !== held ||
                outValid !== 2'b11) begin
                n_fail++;
                $display("FAIL bypass%0d got %h v=%b want %h v=11",
                         j, outB[1], outValid, want);
            end
        end
        @(negedge clk);
        stall   = 1'b0;
        wbValid = 2'b00;
    endtask

    task automatic test_random();
        exp_t e;
        int   bad;
        bad = 0;
        for (int it = 0; it < 24; it++) begin
            @(negedge clk);
            stall   = 1'b0;
            inValid = 2'($urandom);
            inOp[0] = rand_op();
            inOp[1] = rand_op();
            clear   = ($urandom_range(0, 4) == 0);
            sbq.push_back('{v: inValid & {2{~clear}},
                            op1: inOp[1], op0: inOp[0]});
            @(posedge clk); #1;
            clear = 1'b0;
            for (int w = 0; w < 2; w++) begin
                wbValid[w] = 1'($urandom);
                wbDst[w]   = 7'($urandom_range(0, 15));
                wbData[w]  = $urandom;
            end
            #1;
            e = sbq.pop_front();
            n_checks++;
            if (outValid !== e.v || outOp[0] !== e.op0 ||
                outOp[1] !== e.op1 ||
                outA[0] !== exp_opnd(e.op0.srcA) ||
                outB[0] !== exp_opnd(e.op0.srcB) ||
                outA[1] !== exp_opnd(e.op1.srcA) ||
                outB[1] !== exp_opnd(e.op1.srcB)) begin
                n_fail++;
                $display("FAIL random%0d v=%b want %b a0=%h b1=%h",
                         it, outValid, e.v, outA[0], outB[1]);
            end
        end
        wbValid = 2'b00;
    endtask

    task automatic test_flush_stall();
        @(negedge clk);
        stall   = 1'b0;
        toRec   = 1'b0;
        inValid = 2'b11;
        inOp[0] = rand_op();
        inOp[0].alPtr = 6'd62;
        inOp[1] = rand_op();
        inOp[1].alPtr = 6'd5;
        @(posedge clk); #1;
        stall     = 1'b1;
        inValid   = 2'b00;
        toRec     = 1'b1;
        flushAll  = 1'b0;
        flushHead = 6'd60;
        flushTail = 6'd2;
        #1;
        n_checks++;
        if (outValid !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_same_cycle got %b want 10", outValid);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); #1;
            n_checks++;
            if (outValid !== 2'b10) begin
                n_fail++;
                $display("FAIL flush_hold%0d got %b want 10", j, outValid);
            end
        end
        @(negedge clk);
        stall = 1'b0;
        toRec = 1'b0;
        #1;
        n_checks++;
        if (outValid !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_release got %b want 10", outValid);
        end
        @(posedge clk); #1;
        inValid = 2'b01;
        @(posedge clk); #1;
        inValid = 2'b00;
        n_checks++;
        if (outValid !== 2'b01 || outOp[0].alPtr !== 6'd62) begin
            n_fail++;
            $display("FAIL flush_recapture got %b want 01", outValid);
        end
    endtask

    task automatic test_flush_range();
        logic [5:0] tp [10];
        logic [5:0] th [10];
        logic [5:0] tt [10];
        logic       ta [10];
        logic       tk [10];
        tp = '{6'd10, 6'd10, 6'd62, 6'd2, 6'd1, 6'd59, 6'd3, 6'd8, 6'd0, 6'd63};
        th = '{6'd10, 6'd10, 6'd60, 6'd60, 6'd60, 6'd60, 6'd3, 6'd3, 6'd60, 6'd60};
        tt = '{6'd10, 6'd10, 6'd2, 6'd2, 6'd2, 6'd2, 6'd8, 6'd8, 6'd2, 6'd2};
        ta = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tk = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            stall   = 1'b0;
            toRec   = 1'b0;
            inValid = 2'b01;
            inOp[0] = rand_op();
            inOp[0].alPtr = tp[j];
            @(posedge clk); #1;
            stall     = 1'b1;
            inValid   = 2'b00;
            toRec     = 1'b1;
            flushHead = th[j];
            flushTail = tt[j];
            flushAll  = ta[j];
            #1;
            n_checks++;
            if (outValid[0] !== !tk[j]) begin
                n_fail++;
                $display("FAIL range%0d p=%0d got %b want %b",
                         j, tp[j], outValid[0], !tk[j]);
            end
        end
        @(negedge clk);
        stall     = 1'b0;
        flushAll  = 1'b0;
        flushHead = 6'd60;
        flushTail = 6'd2;
        inValid   = 2'b11;
        inOp[0]   = rand_op();
        inOp[0].alPtr = 6'd63;
        inOp[1]   = rand_op();
        inOp[1].alPtr = 6'd30;
        @(posedge clk); #1;
        toRec   = 1'b0;
        inValid = 2'b00;
        n_checks++;
        if (outValid !== 2'b10) begin
            n_fail++;
            $display("FAIL range_capture got %b want 10", outValid);
        end
    endtask

    task automatic test_clear_stall();
        @(negedge clk);
        stall   = 1'b0;
        inValid = 2'b11;
        inOp[0] = rand_op();
        inOp[1] = rand_op();
        @(posedge clk); #1;
        inValid = 2'b00;
        stall   = 1'b1;
        clear   = 1'b1;
        #1;
        n_checks++;
        if (outValid !== 2'b00) begin
            n_fail++;
            $display("FAIL clear_now got %b want 00", outValid);
        end
        @(posedge clk); #1;
        clear = 1'b0;
        #1;
        n_checks++;
        if (outValid !== 2'b00) begin
            n_fail++;
            $display("FAIL clear_held got %b want 00", outValid);
        end
        @(negedge clk);
        stall = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        IntRROp nop;
        @(negedge clk);
        stall   = 1'b0;
        inValid = 2'b11;
        inOp[0] = rand_op();
        inOp[1] = rand_op();
        @(posedge clk); #1;
        inValid = 2'b00;
        stall   = 1'b1;
        #1;
        n_checks++;
        if (outValid !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset got %b want 11", outValid);
        end
        @(negedge clk); #2;
        rstN = 1'b0;
        #1;
        n_checks++;
        if (outValid !== 2'b00 || rfAddr[0] !== 7'd0 ||
            rfAddr[3] !== 7'd0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b a=%0d want 00/0",
                     outValid, rfAddr[0]);
        end
`ifdef RSD_INT_RR_PERF_COUNTER_EN
        n_checks++;
        if (pf !== 32'd0 || ps !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters got %0d/%0d want 0/0", pf, ps);
        end
`endif
        @(negedge clk);
        rstN    = 1'b1;
        stall   = 1'b0;
        inValid = 2'b01;
        nop     = rand_op();
        inOp[0] = nop;
        @(posedge clk); #1;
        inValid = 2'b00;
        n_checks++;
        if (outValid !== 2'b01 || outOp[0] !== nop) begin
            n_fail++;
            $display("FAIL post_reset got %b want 01", outValid);
        end
    endtask

    initial begin
        for (int a = 0; a < 128; a++) rf_mem[a] = $urandom;
        rf_mem[5] = 32'h11;
        rstN      = 1'b0;
        stall     = 1'b0;
        clear     = 1'b0;
        inValid   = 2'b00;
        inOp[0]   = '0;
        inOp[1]   = '0;
        toRec     = 1'b0;
        flushAll  = 1'b0;
        flushHead = '0;
        flushTail = '0;
        wbValid   = 2'b00;
        wbDst[0]  = '0;
        wbDst[1]  = '0;
        wbData[0] = '0;
        wbData[1] = '0;
        test_reset();
`ifdef RSD_INT_RR_PERF_COUNTER_EN
        test_perf();
`endif
        test_basic();
        test_stall_bypass();
        test_random();
        test_flush_stall();
        test_flush_range();
        test_clear_stall();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
